// File: rtl/zeroheti_pkg.sv
// ---------------------------------------------------------------------------
// zeroheti_pkg
//   Shared types and constants for the APB fabric.
//   - apb_rule_t      : one address rule, matches base <= addr < last
//   - fabric_state_e  : transfer FSM states of zeroheti_apb_fabric
//   - DefaultAddrMap  : default 4-entry peripheral map
//   - idx_width()     : width of a port index for n ports (minimum 1)
// ---------------------------------------------------------------------------
package zeroheti_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] last;
    } apb_rule_t;

    typedef enum logic [2:0] {
        FAB_IDLE,
        FAB_SETUP,
        FAB_ACCESS,
        FAB_RESP,
        FAB_ERR
    } fabric_state_e;

    localparam int unsigned DefaultNumPerip = 4;

    // Packed array: the rightmost element is rule 0.
    localparam apb_rule_t [DefaultNumPerip-1:0] DefaultAddrMap = {
        apb_rule_t'{base: 32'h0003_3000, last: 32'h0003_4000},
        apb_rule_t'{base: 32'h0003_2000, last: 32'h0003_3000},
        apb_rule_t'{base: 32'h0003_1000, last: 32'h0003_2000},
        apb_rule_t'{base: 32'h0003_0000, last: 32'h0003_1000}
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zeroheti_apb_if.sv
// ---------------------------------------------------------------------------
// zeroheti_apb_if
//   APB4 bus bundle. NumSel=1 gives a plain manager-side bus; NumSel=N gives
//   a demuxed subordinate bus with one psel/pready/pslverr per port and
//   prdata packed as port k at [k*DataWidth +: DataWidth].
//   modport master : drives psel, penable, pwrite, paddr, pwdata
//   modport slave  : drives prdata, pready, pslverr
// ---------------------------------------------------------------------------
interface zeroheti_apb_if #(
    parameter int unsigned NumSel    = 1,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [NumSel-1:0]           psel;
    logic                        penable;
    logic                        pwrite;
    logic [AddrWidth-1:0]        paddr;
    logic [DataWidth-1:0]        pwdata;
    logic [NumSel*DataWidth-1:0] prdata;
    logic [NumSel-1:0]           pready;
    logic [NumSel-1:0]           pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/zeroheti_apb_addr_decode.sv
// ---------------------------------------------------------------------------
// zeroheti_apb_addr_decode
//   Combinational priority rule matcher. Every rule is compared in parallel;
//   the lowest-index matching rule wins when rules overlap.
//   Ports:
//     addr_i        : address to decode
//     idx_o         : index of the winning rule (0 when nothing matches)
//     match_valid_o : 1 when at least one rule matches
// ---------------------------------------------------------------------------
module zeroheti_apb_addr_decode
    import zeroheti_pkg::*;
#(
    parameter int unsigned               NumPerip  = 4,
    parameter int unsigned               AddrWidth = 32,
    parameter int unsigned               IdxWidth  = 2,
    parameter apb_rule_t [NumPerip-1:0]  AddrMap   = DefaultAddrMap
) (
    input  logic [AddrWidth-1:0] addr_i,
    output logic [IdxWidth-1:0]  idx_o,
    output logic                 match_valid_o
);

    logic [NumPerip-1:0] hit;

    for (genvar gi = 0; gi < NumPerip; gi++) begin : g_rule
        assign hit[gi] = (addr_i >= AddrWidth'(AddrMap[gi].base)) &&
                         (addr_i <  AddrWidth'(AddrMap[gi].last));
    end

    // Walk from the top down so the lowest matching index is written last.
    always_comb begin
        idx_o         = '0;
        match_valid_o = 1'b0;
        for (int i = NumPerip - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx_o         = IdxWidth'(i);
                match_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zeroheti_apb_fabric.sv
// ---------------------------------------------------------------------------
// zeroheti_apb_fabric
//   Registered APB4 decoder/demux: one manager port to NumPerip subordinates.
//   A setup phase is accepted only in IDLE; address, data, direction and
//   decoded port index are latched, and the subordinate side is driven only
//   from those latched values. Unmapped addresses are answered locally with
//   pslverr=1 and ErrData.
//   Ports:
//     clk_i, rst_ni  : clock, asynchronous active-low reset
//     mgr            : manager-facing bus (slave modport, NumSel=1)
//     sub            : subordinate-facing bus (master modport, NumSel=NumPerip)
//     timeout_irq_o  : one-cycle pulse on watchdog abort
//   Optional feature macro: APB_FABRIC_TIMEOUT_EN enables the access-phase
//   watchdog (TimeoutCycles). Without it timeout_irq_o is tied to 0 and
//   ACCESS waits indefinitely.
// ---------------------------------------------------------------------------
module zeroheti_apb_fabric
    import zeroheti_pkg::*;
#(
    parameter int unsigned               NumPerip      = 4,
    parameter int unsigned               AddrWidth     = 32,
    parameter int unsigned               DataWidth     = 32,
    parameter apb_rule_t [NumPerip-1:0]  AddrMap       = DefaultAddrMap,
    parameter int unsigned               TimeoutCycles = 255,
    parameter logic [DataWidth-1:0]      ErrData       = 32'hDEAD_BEEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    zeroheti_apb_if.slave  mgr,
    zeroheti_apb_if.master sub,
    output logic           timeout_irq_o
);

    localparam int unsigned IdxWidth = idx_width(NumPerip);

    fabric_state_e         state_reg, state_next;
    logic [AddrWidth-1:0]  addr_reg, addr_next;
    logic [DataWidth-1:0]  wdata_reg, wdata_next;
    logic                  write_reg, write_next;
    logic [IdxWidth-1:0]   idx_reg, idx_next;
    logic [DataWidth-1:0]  rdata_reg, rdata_next;
    logic                  slverr_reg, slverr_next;

    logic [IdxWidth-1:0]   dec_idx;
    logic                  dec_valid;
    logic                  setup_req;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DataWidth-1:0]  sel_rdata;
    logic                  timeout_hit;

    zeroheti_apb_addr_decode #(
        .NumPerip  (NumPerip),
        .AddrWidth (AddrWidth),
        .IdxWidth  (IdxWidth),
        .AddrMap   (AddrMap)
    ) u_decode (
        .addr_i        (mgr.paddr),
        .idx_o         (dec_idx),
        .match_valid_o (dec_valid)
    );

    assign setup_req = mgr.psel[0] && !mgr.penable;
    assign sel_ready = sub.pready[idx_reg];
    assign sel_err   = sub.pslverr[idx_reg];
    assign sel_rdata = sub.prdata[idx_reg*DataWidth +: DataWidth];

`ifdef APB_FABRIC_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] cnt_reg, cnt_next;
    logic                irq_reg, irq_next;

    assign timeout_hit = (cnt_reg == CntWidth'(TimeoutCycles));

    // Counter is cleared while in SETUP so it starts at 0 on the first
    // ACCESS cycle. A ready seen on the expiry cycle takes precedence.
    always_comb begin
        cnt_next = cnt_reg;
        irq_next = 1'b0;
        if (state_reg == FAB_SETUP) begin
            cnt_next = '0;
        end else if (state_reg == FAB_ACCESS && !sel_ready) begin
            if (timeout_hit) begin
                irq_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
            irq_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            irq_reg <= irq_next;
        end
    end

    assign timeout_irq_o = irq_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles == 0);
    assign timeout_hit        = 1'b0;
    assign timeout_irq_o      = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        write_next  = write_reg;
        idx_next    = idx_reg;
        rdata_next  = rdata_reg;
        slverr_next = slverr_reg;
        case (state_reg)
            FAB_IDLE: begin
                if (setup_req) begin
                    addr_next  = mgr.paddr;
                    wdata_next = mgr.pwdata;
                    write_next = mgr.pwrite;
                    idx_next   = dec_idx;
                    state_next = dec_valid ? FAB_SETUP : FAB_ERR;
                end
            end
            FAB_SETUP: begin
                state_next = FAB_ACCESS;
            end
            FAB_ACCESS: begin
                if (sel_ready) begin
                    rdata_next  = write_reg ? '0 : sel_rdata;
                    slverr_next = sel_err;
                    state_next  = FAB_RESP;
                end else if (timeout_hit) begin
                    state_next = FAB_ERR;
                end
            end
            FAB_RESP: begin
                state_next = FAB_IDLE;
            end
            FAB_ERR: begin
                state_next = FAB_IDLE;
            end
            default: begin
                state_next = FAB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= FAB_IDLE;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            write_reg  <= 1'b0;
            idx_reg    <= '0;
            rdata_reg  <= '0;
            slverr_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            write_reg  <= write_next;
            idx_reg    <= idx_next;
            rdata_reg  <= rdata_next;
            slverr_reg <= slverr_next;
        end
    end

    // psel is decoded straight from the state register, so the async reset
    // removes every select without waiting for a clock edge.
    for (genvar gi = 0; gi < NumPerip; gi++) begin : g_psel
        assign sub.psel[gi] = ((state_reg == FAB_SETUP) || (state_reg == FAB_ACCESS)) &&
                              (idx_reg == IdxWidth'(gi));
    end

    assign sub.penable = (state_reg == FAB_ACCESS);
    assign sub.pwrite  = write_reg;
    assign sub.paddr   = addr_reg;
    assign sub.pwdata  = wdata_reg;

    assign mgr.pready  = (state_reg == FAB_RESP) || (state_reg == FAB_ERR);
    assign mgr.pslverr = (state_reg == FAB_RESP) ? slverr_reg : (state_reg == FAB_ERR);
    assign mgr.prdata  = (state_reg == FAB_RESP) ? rdata_reg :
                         (state_reg == FAB_ERR)  ? ErrData   : '0;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni && state_reg == FAB_IDLE && setup_req && !dec_valid) begin
            $display("zeroheti_apb_fabric: warning: decode error, paddr=0x%h", mgr.paddr);
        end
    end
`endif

endmodule

// File: tb/tb_zeroheti_apb_fabric.sv
module tb_zeroheti_apb_fabric;
    import zeroheti_pkg::*;

    localparam apb_rule_t [3:0] TbMap = {
        apb_rule_t'{base: 32'h0003_0000, last: 32'h0004_0000},
        apb_rule_t'{base: 32'h0003_2000, last: 32'h0003_3000},
        apb_rule_t'{base: 32'h0003_1000, last: 32'h0003_2000},
        apb_rule_t'{base: 32'h0003_0000, last: 32'h0003_1000}
    };
    localparam logic [31:0] ErrWord = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;
    logic irq;

    zeroheti_apb_if #(.NumSel(1), .AddrWidth(32), .DataWidth(32)) mgr_if ();
    zeroheti_apb_if #(.NumSel(4), .AddrWidth(32), .DataWidth(32)) sub_if ();

    zeroheti_apb_fabric #(
        .NumPerip      (4),
        .AddrWidth     (32),
        .DataWidth     (32),
        .AddrMap       (TbMap),
        .TimeoutCycles (8),
        .ErrData       (ErrWord)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .mgr           (mgr_if),
        .sub           (sub_if),
        .timeout_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subordinate model: ready after wait_cfg access cycles.
    logic [31:0] port_data [4];
    logic [3:0]  port_err;
    int          wait_cfg;
    int          wcnt = 0;

    assign sub_if.prdata  = {port_data[3], port_data[2], port_data[1], port_data[0]};
    assign sub_if.pslverr = port_err;
    assign sub_if.pready  = sub_if.psel & {4{sub_if.penable && (wcnt == wait_cfg)}};

    always @(posedge clk) begin
        if ((|sub_if.psel) && sub_if.penable && !(|sub_if.pready)) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [3:0]  psel;
        int          psel_cyc;
        int          pen_cyc;
        int          irq_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one manager transfer starting at posedge+1; expected results are
    // queued at drive time and compared when the fabric raises pready.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int wcfg,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                        input logic [3:0] e_psel, input int e_irq);
        exp_t        e;
        exp_t        got;
        int          k;
        int          psel_cyc;
        int          pen_cyc;
        int          irq_cyc;
        int          bus_bad;
        logic [3:0]  psel_or;
        logic        found;
        logic [31:0] rd;
        logic        er;

        e.tag      = tag;
        e.rdata    = e_rdata;
        e.err      = e_err;
        e.lat      = e_lat;
        e.psel     = e_psel;
        e.psel_cyc = (e_psel != 4'b0) ? e_lat - 1 : 0;
        e.pen_cyc  = (e_psel != 4'b0) ? e_lat - 2 : 0;
        e.irq_cyc  = e_irq;
        sb_q.push_back(e);

        wait_cfg       = wcfg;
        mgr_if.psel    = 1'b1;
        mgr_if.penable = 1'b0;
        mgr_if.pwrite  = wr;
        mgr_if.paddr   = addr;
        mgr_if.pwdata  = wdata;

        psel_cyc = 0; pen_cyc = 0; irq_cyc = 0; bus_bad = 0; psel_or = '0;
        found = 1'b0; rd = '0; er = 1'b0;

        @(negedge clk);
        psel_or |= sub_if.psel;
        if (sub_if.psel != 4'b0) psel_cyc++;
        if (irq) irq_cyc++;
        @(posedge clk); #1;
        mgr_if.penable = 1'b1;
        k = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            psel_or |= sub_if.psel;
            if (sub_if.psel != 4'b0) begin
                psel_cyc++;
                if (sub_if.paddr !== addr || sub_if.pwdata !== wdata || sub_if.pwrite !== wr)
                    bus_bad++;
            end
            if (sub_if.penable) pen_cyc++;
            if (irq) irq_cyc++;
            if (mgr_if.pready[0]) begin
                found = 1'b1;
                rd    = mgr_if.prdata;
                er    = mgr_if.pslverr[0];
                break;
            end
            @(posedge clk); #1;
            k++;
        end

        got = sb_q.pop_front();
        check({got.tag, ".ready_seen"}, found, 1'b1);
        check({got.tag, ".prdata"}, rd, got.rdata);
        check({got.tag, ".pslverr"}, er, got.err);
        check({got.tag, ".latency"}, k, got.lat);
        check({got.tag, ".psel"}, psel_or, got.psel);
        check({got.tag, ".psel_cycles"}, psel_cyc, got.psel_cyc);
        check({got.tag, ".penable_cycles"}, pen_cyc, got.pen_cyc);
        check({got.tag, ".irq_cycles"}, irq_cyc, got.irq_cyc);
        check({got.tag, ".bus_unstable"}, bus_bad, 0);
        $display("xfer %-14s wr=%0d addr=%h lat=%0d psel=%b prdata=%h pslverr=%0d irq=%0d",
                 tag, wr, addr, k, psel_or, rd, er, irq_cyc);

        @(posedge clk); #1;
        mgr_if.psel    = 1'b0;
        mgr_if.penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n          = 1'b0;
        mgr_if.psel    = 1'b0;
        mgr_if.penable = 1'b0;
        mgr_if.pwrite  = 1'b0;
        mgr_if.paddr   = '0;
        mgr_if.pwdata  = '0;
        wait_cfg       = 0;
        port_data[0]   = 32'hAAAA_0000;
        port_data[1]   = 32'h1111_2222;
        port_data[2]   = 32'h1234_5678;
        port_data[3]   = 32'h3333_4444;
        port_err       = 4'b0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.sub_psel", sub_if.psel, 4'b0);
        check("rst.sub_penable", sub_if.penable, 1'b0);
        check("rst.sub_paddr", sub_if.paddr, 32'h0);
        check("rst.sub_pwdata", sub_if.pwdata, 32'h0);
        check("rst.sub_pwrite", sub_if.pwrite, 1'b0);
        check("rst.mgr_pready", mgr_if.pready, 1'b0);
        check("rst.mgr_pslverr", mgr_if.pslverr, 1'b0);
        check("rst.mgr_prdata", mgr_if.prdata, 32'h0);
        check("rst.irq", irq, 1'b0);
        $display("reset state checked");

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("rd_p2",         1'b0, 32'h0003_2010, 32'h0,          0, 32'h1234_5678, 1'b0, 3, 4'b0100, 0);
        xfer("wr_p0_wait5",   1'b1, 32'h0003_0040, 32'hCAFE_F00D,  5, 32'h0,         1'b0, 8, 4'b0001, 0);
        xfer("rd_unmapped",   1'b0, 32'h0005_0000, 32'h0,          0, ErrWord,       1'b1, 1, 4'b0000, 0);
        xfer("rd_overlap",    1'b0, 32'h0003_0000, 32'h0,          0, 32'hAAAA_0000, 1'b0, 3, 4'b0001, 0);
        xfer("rd_r0_last",    1'b0, 32'h0003_1000, 32'h0,          0, 32'h1111_2222, 1'b0, 3, 4'b0010, 0);
        port_err = 4'b1000;
        xfer("rd_p3_slverr",  1'b0, 32'h0003_3FFC, 32'h0,          1, 32'h3333_4444, 1'b1, 4, 4'b1000, 0);
        port_err = 4'b0000;
        xfer("rd_r3_last",    1'b0, 32'h0004_0000, 32'h0,          0, ErrWord,       1'b1, 1, 4'b0000, 0);
        xfer("wr_unmapped",   1'b1, 32'h0000_0000, 32'h5555_AAAA,  0, ErrWord,       1'b1, 1, 4'b0000, 0);

        // Reset asserted while the subordinate is stalling in ACCESS.
        wait_cfg       = 255;
        mgr_if.psel    = 1'b1;
        mgr_if.penable = 1'b0;
        mgr_if.pwrite  = 1'b0;
        mgr_if.paddr   = 32'h0003_1008;
        mgr_if.pwdata  = 32'h0;
        @(posedge clk); #1;
        mgr_if.penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid.penable_before", sub_if.penable, 1'b1);
        check("rstmid.psel_before", sub_if.psel, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.psel_after", sub_if.psel, 4'b0000);
        check("rstmid.penable_after", sub_if.penable, 1'b0);
        check("rstmid.pready_after", mgr_if.pready, 1'b0);
        check("rstmid.paddr_after", sub_if.paddr, 32'h0);
        $display("xfer rst_mid_access psel_after=%b pready_after=%0d", sub_if.psel, mgr_if.pready);
        repeat (2) @(posedge clk);
        #1;
        mgr_if.psel    = 1'b0;
        mgr_if.penable = 1'b0;
        rst_n          = 1'b1;
        @(posedge clk); #1;

        xfer("rd_after_rst",  1'b0, 32'h0003_1004, 32'h0,          0, 32'h1111_2222, 1'b0, 3, 4'b0010, 0);

`ifdef APB_FABRIC_TIMEOUT_EN
        xfer("to_never",      1'b0, 32'h0003_2000, 32'h0,        255, ErrWord,       1'b1, 11, 4'b0100, 1);
        xfer("to_same_cycle", 1'b0, 32'h0003_2004, 32'h0,          8, 32'h1234_5678, 1'b0, 11, 4'b0100, 0);
        xfer("to_8th_cycle",  1'b1, 32'h0003_2008, 32'h0BAD_CAFE,  7, 32'h0,         1'b0, 10, 4'b0100, 0);
        xfer("to_recover",    1'b0, 32'h0003_0010, 32'h0,          0, 32'hAAAA_0000, 1'b0, 3, 4'b0001, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
